// File: rtl/interconnect_pkg.sv
// Shared definitions for the sample-stream crossbar: lane state encoding and
// counter sizing helpers.
package interconnect_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } lane_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // The blank counter holds 0..BLANK_CYCLES-1 and needs at least one bit.
  function automatic int unsigned cnt_width(input int unsigned blank_cycles);
    int unsigned w;
    w = clog2(blank_cycles);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/crossbar_interconnect_if.sv
// Bundled sample/select bus between the acquisition cores, the crossbar and
// its DMA/DAC consumers.
interface crossbar_interconnect_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned N_OUTPUTS = 2,
  parameter int unsigned SEL_WIDTH = 2
);

  logic [N_INPUTS*WIDTH-1:0]      in;
  logic [N_INPUTS-1:0]            in_valid;
  logic [N_OUTPUTS*SEL_WIDTH-1:0] sel;
  logic [N_OUTPUTS-1:0]           sel_load;
  logic [N_OUTPUTS*WIDTH-1:0]     out;
  logic [N_OUTPUTS-1:0]           out_valid;
  logic [N_OUTPUTS-1:0]           switching;

  modport master (
    output in, in_valid, sel, sel_load,
    input  out, out_valid, switching
  );

  modport slave (
    input  in, in_valid, sel, sel_load,
    output out, out_valid, switching
  );

endinterface

// File: rtl/interconnect_lane.sv
// One crossbar output lane: select FSM with blanking counter, input mux and
// a LATENCY-deep output pipeline.
module interconnect_lane
  import interconnect_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned N_INPUTS     = 4,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_INPUTS*WIDTH-1:0] in,
  input  logic [N_INPUTS-1:0]       in_valid,
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      sel_load,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  output logic                      switching
);

  localparam int unsigned         CNT_W      = cnt_width(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(BLANK_CYCLES - 1);

  lane_state_t          state, state_nx;
  logic [SEL_WIDTH-1:0] active_sel, active_sel_nx;
  logic [SEL_WIDTH-1:0] pending, pending_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;

  logic [WIDTH-1:0]     src_data;
  logic                 src_valid;
  logic [WIDTH-1:0]     pipe_data  [LATENCY];
  logic                 pipe_valid [LATENCY];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RUN;
      active_sel <= '0;
      pending    <= '0;
      cnt        <= '0;
      switching  <= 1'b0;
    end else begin
      state      <= state_nx;
      active_sel <= active_sel_nx;
      pending    <= pending_nx;
      cnt        <= cnt_nx;
      switching  <= (state_nx == ST_BLANK);
    end
  end

  // A fresh select during BLANK restarts the count, even on its last cycle.
  always_comb begin
    state_nx      = state;
    active_sel_nx = active_sel;
    pending_nx    = pending;
    cnt_nx        = cnt;
    unique case (state)
      ST_RUN: begin
        if (sel_load && (sel != active_sel)) begin
          pending_nx = sel;
          cnt_nx     = CNT_RELOAD;
          state_nx   = ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (sel_load && (sel != pending)) begin
          pending_nx = sel;
          cnt_nx     = CNT_RELOAD;
        end else if (cnt == '0) begin
          active_sel_nx = pending;
          state_nx      = ST_RUN;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  // Out-of-range selects match no input and therefore feed zeros.
  always_comb begin
    src_data  = '0;
    src_valid = 1'b0;
    if (state == ST_RUN) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        if (active_sel == SEL_WIDTH'(i)) begin
          src_data  = in[i*WIDTH +: WIDTH];
          src_valid = in_valid[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_data[i]  <= '0;
        pipe_valid[i] <= 1'b0;
      end
    end else begin
      pipe_data[0]  <= src_data;
      pipe_valid[0] <= src_valid;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_data[i]  <= pipe_data[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  assign out       = pipe_data[LATENCY-1];
  assign out_valid = pipe_valid[LATENCY-1];

endmodule

// File: rtl/crossbar_interconnect.sv
// Registered N_INPUTS x N_OUTPUTS sample crossbar with per-lane atomic select
// and post-switch blanking; one interconnect_lane per output.
module crossbar_interconnect #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned N_INPUTS     = 4,
  parameter int unsigned N_OUTPUTS    = 2,
  parameter int unsigned SEL_WIDTH    = 2,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  crossbar_interconnect_if.slave   bus
);

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_lane
    interconnect_lane #(
      .WIDTH        (WIDTH),
      .N_INPUTS     (N_INPUTS),
      .SEL_WIDTH    (SEL_WIDTH),
      .LATENCY      (LATENCY),
      .BLANK_CYCLES (BLANK_CYCLES)
    ) u_lane (
      .clk       (clk),
      .resetn    (resetn),
      .in        (bus.in),
      .in_valid  (bus.in_valid),
      .sel       (bus.sel[k*SEL_WIDTH +: SEL_WIDTH]),
      .sel_load  (bus.sel_load[k]),
      .out       (bus.out[k*WIDTH +: WIDTH]),
      .out_valid (bus.out_valid[k]),
      .switching (bus.switching[k])
    );
  end

endmodule

// File: tb/tb_crossbar_interconnect.sv
// Directed scoreboard bench for crossbar_interconnect (2 lanes, 4 inputs,
// LATENCY=2, BLANK_CYCLES=4).
module tb_crossbar_interconnect;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic [1:0]  vld;
    logic [1:0]  sw;
  } exp_t;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  crossbar_interconnect_if #(
    .WIDTH     (8),
    .N_INPUTS  (4),
    .N_OUTPUTS (2),
    .SEL_WIDTH (2)
  ) bus ();

  crossbar_interconnect #(
    .WIDTH        (8),
    .N_INPUTS     (4),
    .N_OUTPUTS    (2),
    .SEL_WIDTH    (2),
    .LATENCY      (2),
    .BLANK_CYCLES (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus now, queue the outputs expected after the
  // next rising edge, then advance to the following falling edge.
  task automatic step(input string nm, input logic [1:0] ld, input logic [3:0] s,
                      input logic [15:0] e_out, input logic [1:0] e_vld,
                      input logic [1:0] e_sw);
    exp_t e;
    bus.sel_load = ld;
    bus.sel      = s;
    e.name = nm;
    e.out  = e_out;
    e.vld  = e_vld;
    e.sw   = e_sw;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".out"},       bus.out,                e.out);
      chk({e.name, ".valid"},     {14'd0, bus.out_valid}, {14'd0, e.vld});
      chk({e.name, ".switching"}, {14'd0, bus.switching}, {14'd0, e.sw});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    resetn       = 1'b0;
    bus.in       = 32'h44332211;
    bus.in_valid = 4'hF;
    bus.sel      = '0;
    bus.sel_load = '0;

    #7;
    chk("reset.out",       bus.out,                16'h0000);
    chk("reset.valid",     {14'd0, bus.out_valid}, 16'h0000);
    chk("reset.switching", {14'd0, bus.switching}, 16'h0000);
    @(negedge clk);
    resetn = 1'b1;

    // Pipeline fill after reset: both lanes on input 0
    step("t1.fill0", 2'b00, 4'b0000, 16'h0000, 2'b00, 2'b00);
    step("t1.fill1", 2'b00, 4'b0000, 16'h1111, 2'b11, 2'b00);
    step("t1.hold",  2'b00, 4'b0000, 16'h1111, 2'b11, 2'b00);

    // Lane0 -> input 2
    step("t2.load",  2'b01, 4'b0010, 16'h1111, 2'b11, 2'b01);
    step("t2.b1",    2'b00, 4'b0000, 16'h1111, 2'b11, 2'b01);
    step("t2.b2",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t2.b3",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t2.b4",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t2.b5",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t2.new",   2'b00, 4'b0000, 16'h1133, 2'b11, 2'b00);
    step("t2.hold",  2'b00, 4'b0000, 16'h1133, 2'b11, 2'b00);

    // Lane0 -> 1, then -> 3 two cycles later: blank restarts
    step("t3.load1", 2'b01, 4'b0001, 16'h1133, 2'b11, 2'b01);
    step("t3.b1",    2'b00, 4'b0000, 16'h1133, 2'b11, 2'b01);
    step("t3.load3", 2'b01, 4'b0011, 16'h1100, 2'b10, 2'b01);
    step("t3.b3",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t3.b4",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t3.b5",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t3.b6",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t3.b7",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t3.new",   2'b00, 4'b0000, 16'h1144, 2'b11, 2'b00);

    // Lane1 reloads its current select (0): no effect
    step("t4.same",  2'b10, 4'b0011, 16'h1144, 2'b11, 2'b00);
    step("t4.h1",    2'b00, 4'b0000, 16'h1144, 2'b11, 2'b00);
    step("t4.h2",    2'b00, 4'b0000, 16'h1144, 2'b11, 2'b00);

    // Lane0 back to input 2, then drop in_valid[2] with new data
    step("t5.load",  2'b01, 4'b0010, 16'h1144, 2'b11, 2'b01);
    step("t5.b1",    2'b00, 4'b0000, 16'h1144, 2'b11, 2'b01);
    step("t5.b2",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t5.b3",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b01);
    step("t5.b4",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t5.b5",    2'b00, 4'b0000, 16'h1100, 2'b10, 2'b00);
    step("t5.new",   2'b00, 4'b0000, 16'h1133, 2'b11, 2'b00);
    bus.in       = 32'h445A2211;
    bus.in_valid = 4'b1011;
    step("t5.inv0",  2'b00, 4'b0000, 16'h1133, 2'b11, 2'b00);
    step("t5.inv1",  2'b00, 4'b0000, 16'h115A, 2'b10, 2'b00);
    bus.in       = 32'h44332211;
    bus.in_valid = 4'hF;
    step("t5.rst0",  2'b00, 4'b0000, 16'h115A, 2'b10, 2'b00);
    step("t5.rst1",  2'b00, 4'b0000, 16'h1133, 2'b11, 2'b00);

    // Async reset in the middle of a blank
    step("t6.load",  2'b01, 4'b0001, 16'h1133, 2'b11, 2'b01);
    step("t6.b1",    2'b00, 4'b0000, 16'h1133, 2'b11, 2'b01);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6.rst.out",       bus.out,                16'h0000);
    chk("t6.rst.valid",     {14'd0, bus.out_valid}, 16'h0000);
    chk("t6.rst.switching", {14'd0, bus.switching}, 16'h0000);
    resetn = 1'b1;
    step("t6.fill0", 2'b00, 4'b0000, 16'h0000, 2'b00, 2'b00);
    step("t6.fill1", 2'b00, 4'b0000, 16'h1111, 2'b11, 2'b00);
    step("t6.hold",  2'b00, 4'b0000, 16'h1111, 2'b11, 2'b00);

    chk("drain", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
